// File: rtl/fsm_tick_timer.sv
// rtl/fsm_tick_timer.sv - synchronized slow-clock tick generator with loadable countdown FSM
// Optional AUTO_RELOAD_EN: expiry reloads the last loaded value and stays in RUN.
`timescale 1ns/1ps
module fsm_tick_timer #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock_50,
  input  logic             reset,
  input  logic             c025hz,
  input  logic             c05hz,
  input  logic             c1hz,
  input  logic             c2hz,
  input  logic [1:0]       sel,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  output logic [CNT_W-1:0] count,
  output logic             tick,
  output logic             running,
  output logic             done
);

  localparam int SS     = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int MASK_W = $clog2(SS + 2);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [3:0]        wave_in;
  logic [3:0]        sync_q [SS];
  logic [3:0]        hist_q;
  logic [3:0]        rise;
  logic [MASK_W-1:0] mask_q;
  logic              armed;
  logic              tick_q, tick_d;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              done_q, done_d;
`ifdef AUTO_RELOAD_EN
  logic [CNT_W-1:0]  reload_q, reload_d;
`endif

  // Bit order matches sel encoding so rise[sel] picks the source directly.
  assign wave_in = {c2hz, c1hz, c05hz, c025hz};
  assign rise    = sync_q[SS-1] & ~hist_q;
  assign armed   = (mask_q == MASK_W'(SS + 1));

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SS; i++) begin
        sync_q[i] <= '0;
      end
      hist_q <= '0;
      mask_q <= '0;
    end else begin
      sync_q[0] <= wave_in;
      for (int i = 1; i < SS; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      hist_q <= sync_q[SS-1];
      if (!armed) begin
        mask_q <= mask_q + MASK_W'(1);
      end
    end
  end

  // A sel switch onto a source that rose one cycle after the previous tick is dropped.
  assign tick_d = armed & rise[sel] & ~tick_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    done_d   = 1'b0;
`ifdef AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          count_d  = load_val;
`ifdef AUTO_RELOAD_EN
          reload_d = load_val;
`endif
        end
        if (start && ((load ? load_val : count_q) != '0)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (pause) begin
          state_d = ST_PAUSED;
        end else if (tick_q) begin
          if (count_q == CNT_W'(1)) begin
            done_d  = 1'b1;
`ifdef AUTO_RELOAD_EN
            count_d = reload_q;
`else
            count_d = '0;
            state_d = ST_DONE;
`endif
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end
      end
      ST_PAUSED: begin
        if (!pause) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        count_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      tick_q   <= 1'b0;
      state_q  <= ST_IDLE;
      count_q  <= '0;
      done_q   <= 1'b0;
`ifdef AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      tick_q   <= tick_d;
      state_q  <= state_d;
      count_q  <= count_d;
      done_q   <= done_d;
`ifdef AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign count   = count_q;
  assign tick    = tick_q;
  assign done    = done_q;
  assign running = (state_q == ST_RUN) || (state_q == ST_PAUSED);

endmodule
